// File: rtl/mem_arbiter_if.sv
// Requester-side bus of mem_arbiter: fetch (F) and load/store (D) handshakes plus shared read data.
interface mem_arbiter_if #(
   parameter int AW = 5,
   parameter int DW = 16
);
   logic          f_req;
   logic [AW-1:0] f_addr;
   logic          f_ack;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_ack;
   logic [DW-1:0] rdata;
   logic          busy;

   modport master (
      output f_req, f_addr, d_req, d_we, d_addr, d_wdata,
      input  f_ack, d_ack, rdata, busy
   );

   modport slave (
      input  f_req, f_addr, d_req, d_we, d_addr, d_wdata,
      output f_ack, d_ack, rdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch (F) and load/store (D): IDLE -> ACCESS -> RESP per access.
// Define ARB_RR_EN for round-robin on contention; otherwise fixed priority D > F.
module mem_arbiter #(
   parameter int AW = 5,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_in,
   output logic          mem_write_n,
   output logic          mem_read_n,
   input  logic [DW-1:0] mem_out
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t        state, state_n;
   logic          f_ack, f_ack_n, d_ack, d_ack_n, busy;
   logic [DW-1:0] rdata, rdata_n;
   logic [AW-1:0] addr_n;
   logic [DW-1:0] din_n;
   logic          wr_n_n, rd_n_n;
   logic          gnt_d, gnt_d_n, gnt_we, gnt_we_n;
   logic          pick_d;
`ifdef ARB_RR_EN
   logic          last_d, last_d_n;
`endif

   // Winner when in IDLE; only meaningful if some request is present.
   always_comb begin
`ifdef ARB_RR_EN
      pick_d = bus.d_req && (!bus.f_req || !last_d);
`else
      pick_d = bus.d_req;
`endif
   end

   always_comb begin
      state_n  = state;
      f_ack_n  = 1'b0;
      d_ack_n  = 1'b0;
      rdata_n  = rdata;
      addr_n   = mem_addr;
      din_n    = mem_in;
      wr_n_n   = 1'b1;
      rd_n_n   = 1'b1;
      gnt_d_n  = gnt_d;
      gnt_we_n = gnt_we;
`ifdef ARB_RR_EN
      last_d_n = last_d;
`endif
      case (state)
         IDLE: begin
            if (bus.f_req || bus.d_req) begin
               state_n = ACCESS;
               gnt_d_n = pick_d;
               if (pick_d) begin
                  addr_n   = bus.d_addr;
                  din_n    = bus.d_wdata;
                  gnt_we_n = bus.d_we;
               end else begin
                  addr_n   = bus.f_addr;
                  gnt_we_n = 1'b0;
               end
               wr_n_n = ~gnt_we_n;
               rd_n_n = gnt_we_n;
`ifdef ARB_RR_EN
               last_d_n = pick_d;
`endif
            end
         end
         ACCESS: begin
            if (!gnt_we) rdata_n = mem_out;
            f_ack_n = ~gnt_d;
            d_ack_n = gnt_d;
            state_n = RESP;
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         f_ack       <= 1'b0;
         d_ack       <= 1'b0;
         rdata       <= '0;
         mem_addr    <= '0;
         mem_in      <= '0;
         mem_write_n <= 1'b1;
         mem_read_n  <= 1'b1;
         busy        <= 1'b0;
         gnt_d       <= 1'b0;
         gnt_we      <= 1'b0;
`ifdef ARB_RR_EN
         last_d      <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         f_ack       <= f_ack_n;
         d_ack       <= d_ack_n;
         rdata       <= rdata_n;
         mem_addr    <= addr_n;
         mem_in      <= din_n;
         mem_write_n <= wr_n_n;
         mem_read_n  <= rd_n_n;
         busy        <= (state_n != IDLE);
         gnt_d       <= gnt_d_n;
         gnt_we      <= gnt_we_n;
`ifdef ARB_RR_EN
         last_d      <= last_d_n;
`endif
      end
   end

   assign bus.f_ack = f_ack;
   assign bus.d_ack = d_ack;
   assign bus.rdata = rdata;
   assign bus.busy  = busy;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural memory and reference model.
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  mem_addr;
   logic [15:0] mem_in;
   logic        mem_write_n, mem_read_n;
   logic [15:0] mem_out = '0;
   logic [15:0] mem [32];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   mem_arbiter_if #(.AW(5), .DW(16)) bus ();

   mem_arbiter #(.AW(5), .DW(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .mem_addr(mem_addr), .mem_in(mem_in),
      .mem_write_n(mem_write_n), .mem_read_n(mem_read_n), .mem_out(mem_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory acts on the negedge inside the strobe cycle.
   always @(negedge clk) begin
      if (!mem_write_n) mem[mem_addr] <= mem_in;
      if (!mem_read_n)  mem_out <= mem[mem_addr];
   end

   typedef struct {
      logic       is_d;
      logic       we;
      logic [4:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
   } txn_t;

   txn_t        ack_q[$];
   txn_t        mem_q[$];
   logic [15:0] ref_mem [32];
   logic [15:0] ref_rdata = '0;
   bit          ref_last_d = 1'b0;

   function automatic logic [15:0] init_word(input int i);
      logic [15:0] w;
      w = 16'(i) * 16'h0101;
      return w ^ 16'h02F0;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Contention rule: fixed D priority, or the port not granted last.
   function automatic bit model_prefers_d();
`ifdef ARB_RR_EN
      return !ref_last_d;
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_grant(input bit is_d, input bit we, input logic [4:0] a, input logic [15:0] wd);
      txn_t t;
      if (we) ref_mem[a] = wd;
      else    ref_rdata  = ref_mem[a];
      t.is_d = is_d; t.we = we; t.addr = a; t.wdata = wd; t.rdata = ref_rdata;
      ack_q.push_back(t);
      mem_q.push_back(t);
      ref_last_d = is_d;
   endtask

   // Monitor: compares every strobe and every ack against the scoreboard.
   initial begin
      bit   prev_strobe, strobe;
      txn_t e;
      prev_strobe = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            strobe = !mem_write_n || !mem_read_n;
            if (strobe) begin
               check("strobe_1cyc", {31'b0, prev_strobe}, 32'd0);
               check("strobe_excl", {31'b0, !mem_write_n && !mem_read_n}, 32'd0);
               if (mem_q.size() == 0) check("mem_unexpected", 32'd1, {31'b0, 1'b0});
               else begin
                  e = mem_q.pop_front();
                  check("mem_addr", {27'b0, mem_addr}, {27'b0, e.addr});
                  check("mem_we", {31'b0, !mem_write_n}, {31'b0, e.we});
                  if (e.we) check("mem_in", {16'b0, mem_in}, {16'b0, e.wdata});
               end
            end
            if (bus.f_ack || bus.d_ack) begin
               check("ack_excl", {31'b0, bus.f_ack && bus.d_ack}, 32'd0);
               check("ack_latency", {31'b0, prev_strobe}, 32'd1);
               if (ack_q.size() == 0) check("ack_unexpected", {31'b0, bus.d_ack}, {31'b0, bus.f_ack});
               else begin
                  e = ack_q.pop_front();
                  check("ack_port_d", {31'b0, bus.d_ack}, {31'b0, e.is_d});
                  check("rdata", {16'b0, bus.rdata}, {16'b0, e.rdata});
               end
            end
            prev_strobe = strobe;
         end else prev_strobe = 1'b0;
      end
   end

   task automatic issue(input bit df, input logic [4:0] fa, input bit dd, input bit dwe,
                        input logic [4:0] da, input logic [15:0] dwd, input bit drop_early);
      bit pf, pd;
      int budget;
      @(negedge clk);
      if (dd && (!df || model_prefers_d())) begin
         model_grant(1'b1, dwe, da, dwd);
         if (df) model_grant(1'b0, 1'b0, fa, '0);
      end else begin
         if (df) model_grant(1'b0, 1'b0, fa, '0);
         if (dd) model_grant(1'b1, dwe, da, dwd);
      end
      bus.f_req = df; bus.f_addr = fa;
      bus.d_req = dd; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd;
      pf = df; pd = dd; budget = 0;
      while ((pf || pd) && budget < 40) begin
         @(negedge clk);
         budget++;
         if (drop_early && pd && (!mem_read_n || !mem_write_n)) bus.d_req = 1'b0;
         if (pf && bus.f_ack) begin bus.f_req = 1'b0; pf = 1'b0; end
         if (pd && bus.d_ack) begin bus.d_req = 1'b0; pd = 1'b0; end
      end
      check("ack_timeout", {31'b0, pf | pd}, 32'd0);
      bus.f_req = 1'b0; bus.d_req = 1'b0;
   endtask

   // Both ports hold req; each ack presents that port's next address.
   task automatic contend(input int n);
      logic [4:0]  fa [8];
      logic [4:0]  da [8];
      logic        dwe [8];
      logic [15:0] dwd [8];
      int fi, di, acks, budget, last_cyc;
      for (int k = 0; k < 8; k++) begin
         fa[k] = 5'($urandom); da[k] = 5'($urandom);
         dwe[k] = 1'($urandom); dwd[k] = 16'($urandom);
      end
      @(negedge clk);
      fi = 0; di = 0;
      for (int k = 0; k < n; k++) begin
         if (model_prefers_d()) begin model_grant(1'b1, dwe[di], da[di], dwd[di]); di++; end
         else begin model_grant(1'b0, 1'b0, fa[fi], '0); fi++; end
      end
      fi = 0; di = 0; acks = 0; budget = 0; last_cyc = -1;
      bus.f_addr = fa[0]; bus.d_addr = da[0]; bus.d_we = dwe[0]; bus.d_wdata = dwd[0];
      bus.f_req = 1'b1; bus.d_req = 1'b1;
      while (acks < n && budget < 60) begin
         @(negedge clk);
         budget++;
         if (bus.f_ack || bus.d_ack) begin
            acks++;
            if (last_cyc >= 0) check("ack_spacing", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
            if (bus.f_ack) begin fi++; bus.f_addr = fa[fi]; end
            if (bus.d_ack) begin
               di++; bus.d_addr = da[di]; bus.d_we = dwe[di]; bus.d_wdata = dwd[di];
            end
         end
      end
      check("contend_timeout", 32'(acks), 32'(n));
      bus.f_req = 1'b0; bus.d_req = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         mem[i] = init_word(i);
         ref_mem[i] = init_word(i);
      end
      bus.f_req = 1'b0; bus.f_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      repeat (10) begin
         @(negedge clk);
         check("idle_wr_n", {31'b0, mem_write_n}, 32'd1);
         check("idle_rd_n", {31'b0, mem_read_n}, 32'd1);
         check("idle_acks", {30'b0, bus.f_ack, bus.d_ack}, 32'd0);
         check("idle_busy", {31'b0, bus.busy}, 32'd0);
         check("idle_rdata", {16'b0, bus.rdata}, 32'd0);
      end

      issue(1'b1, 5'd0, 1'b0, 1'b0, '0, '0, 1'b0);
      issue(1'b0, '0, 1'b1, 1'b1, 5'd5, 16'hA5A5, 1'b0);
      issue(1'b1, 5'd5, 1'b0, 1'b0, '0, '0, 1'b0);

      contend(4);
      repeat (2) @(negedge clk);

      // Reset during the ACCESS cycle of a D read.
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 5'd9;
      @(posedge clk);
      #1;
      check("rst_pre_rd_n", {31'b0, mem_read_n}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("rst_wr_n", {31'b0, mem_write_n}, 32'd1);
      check("rst_rd_n", {31'b0, mem_read_n}, 32'd1);
      check("rst_busy", {31'b0, bus.busy}, 32'd0);
      repeat (3) begin
         @(negedge clk);
         check("rst_no_dack", {31'b0, bus.d_ack}, 32'd0);
      end
      bus.d_req = 1'b0;
      rst_n = 1'b1;
      ref_last_d = 1'b0;
      ref_rdata = '0;
      issue(1'b1, 5'd7, 1'b0, 1'b0, '0, '0, 1'b0);

      issue(1'b0, '0, 1'b1, 1'b0, 5'd12, '0, 1'b1);
      issue(1'b0, '0, 1'b1, 1'b1, 5'd13, 16'h1234, 1'b1);
      repeat (5) @(negedge clk);
      check("drop_idle_busy", {31'b0, bus.busy}, 32'd0);

      for (int k = 0; k < 150; k++) begin
         bit df, dd;
         df = 1'($urandom);
         dd = 1'($urandom);
         if (df || dd)
            issue(df, 5'($urandom), dd, 1'($urandom), 5'($urandom), 16'($urandom), 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      check("ack_q_empty", 32'(ack_q.size()), 32'd0);
      check("mem_q_empty", 32'(mem_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
